// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Memory-side responder for the cache strobe/ready port. Each accepted
//   request becomes one single-beat AXI4 read or write. Completion is
//   signalled by a one-cycle m_ready pulse, with read data on m_dout.
//
//   Ports:
//     clk, clrn                   clock, asynchronous active-low reset
//     m_a, m_din, m_strobe, m_rw  cache request (m_rw: 0 read, 1 write)
//     m_dout, m_ready             read data / completion pulse
//     araddr/arvalid/arready      AXI read address channel
//     rdata/rresp/rvalid/rready   AXI read data channel
//     awaddr/awvalid/awready      AXI write address channel
//     wdata/wstrb/wvalid/wready   AXI write data channel
//     bresp/bvalid/bready         AXI write response channel
//     m_err                       error flag in the m_ready cycle
//                                 (only when BRIDGE_ERR_EN is defined)
//
//   Optional feature macro: BRIDGE_ERR_EN
module cache_axi_bridge #(
  parameter int A_WIDTH = 32
) (
`ifdef BRIDGE_ERR_EN
  output logic               m_err,
`endif
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  input  logic               m_strobe,
  input  logic               m_rw,
  output logic [31:0]        m_dout,
  output logic               m_ready,
  output logic [A_WIDTH-1:0] araddr,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  // Full-word writes only.
  assign wstrb = 4'hF;

  always_comb begin
    aw_hs = awvalid & awready;
    w_hs  = wvalid & wready;
  end

`ifndef BRIDGE_ERR_EN
  // Response codes are not reported in this build.
  logic unused_resp;
  assign unused_resp = ^{rresp, bresp};
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      m_dout  <= '0;
      m_ready <= 1'b0;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef BRIDGE_ERR_EN
      m_err   <= 1'b0;
`endif
    end else begin
      // m_ready (and m_err) are set only on entry to DONE, so they fall
      // back to 0 on the following cycle.
      m_ready <= 1'b0;
`ifdef BRIDGE_ERR_EN
      m_err   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (m_strobe) begin
            if (m_rw) begin
              awaddr  <= m_a;
              wdata   <= m_din;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end else begin
              araddr  <= m_a;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end

        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            m_dout  <= rdata;
            rready  <= 1'b0;
            m_ready <= 1'b1;
`ifdef BRIDGE_ERR_EN
            m_err   <= (rresp != 2'b00);
`endif
            state   <= DONE;
          end
        end

        WR_REQ: begin
          // Address and data channels complete independently; the done
          // flags remember a handshake that happened in an earlier cycle.
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready  <= 1'b0;
            m_ready <= 1'b1;
`ifdef BRIDGE_ERR_EN
            m_err   <= (bresp != 2'b00);
`endif
            state   <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed and randomized checks for cache_axi_bridge. A reactive AXI
// slave applies a configurable wait count on each channel; expected
// per-cycle outputs come from the cycle-numbering rules of the bridge.
module tb_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] m_a;
  logic [31:0] m_din;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_dout;
  logic        m_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
`ifdef BRIDGE_ERR_EN
  logic        m_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_dout;

  always #5 clk = ~clk;

  cache_axi_bridge #(.A_WIDTH(32)) dut (
`ifdef BRIDGE_ERR_EN
    .m_err(m_err),
`endif
    .clk(clk),
    .clrn(clrn),
    .m_a(m_a),
    .m_din(m_din),
    .m_strobe(m_strobe),
    .m_rw(m_rw),
    .m_dout(m_dout),
    .m_ready(m_ready),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready),
    .awaddr(awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata),
    .wstrb(wstrb),
    .wvalid(wvalid),
    .wready(wready),
    .bresp(bresp),
    .bvalid(bvalid),
    .bready(bready)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_quiet();
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = $urandom;
    rresp   = 2'($urandom);
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'($urandom);
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      chk1("idle_arvalid", arvalid, 1'b0);
      chk1("idle_rready", rready, 1'b0);
      chk1("idle_awvalid", awvalid, 1'b0);
      chk1("idle_wvalid", wvalid, 1'b0);
      chk1("idle_bready", bready, 1'b0);
      chk1("idle_m_ready", m_ready, 1'b0);
      chk32("idle_m_dout", m_dout, model_dout);
`ifdef BRIDGE_ERR_EN
      chk1("idle_m_err", m_err, 1'b0);
`endif
      slave_quiet();
    end
  endtask

  // One request. Read: w1 = arready wait, w2 = rvalid wait.
  // Write: w1 = awready wait, w2 = wready wait, w3 = bvalid wait.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] din,
                         input int unsigned w1, input int unsigned w2, input int unsigned w3,
                         input logic [31:0] rd_val, input logic [1:0] resp, input bit keep);
    int unsigned m, d;
    int unsigned n1, n2, n3;
    logic [31:0] capt;
    logic obs_ar, obs_r, obs_aw, obs_w, obs_b;
    n1 = 0; n2 = 0; n3 = 0;
    capt = '0;
    m = (w1 > w2) ? w1 : w2;
    d = rw ? (3 + m + w3) : (3 + w1 + w2);

    step();  // cycle 0: bridge is idle
    chk1("c0_arvalid", arvalid, 1'b0);
    chk1("c0_awvalid", awvalid, 1'b0);
    chk1("c0_m_ready", m_ready, 1'b0);
    m_strobe = 1'b1;
    m_rw     = rw;
    m_a      = addr;
    m_din    = din;
    slave_quiet();

    for (int unsigned c = 1; c <= d; c++) begin
      step();
      if (!rw) begin
        chk1("rd_arvalid", arvalid, (c <= 1 + w1));
        if (c <= 1 + w1) chk32("rd_araddr", araddr, addr);
        chk1("rd_rready", rready, (c >= 2 + w1) && (c <= 2 + w1 + w2));
        chk1("rd_awvalid", awvalid, 1'b0);
        chk1("rd_wvalid", wvalid, 1'b0);
        chk1("rd_bready", bready, 1'b0);
        if (c == d) model_dout = capt;
      end else begin
        chk1("wr_awvalid", awvalid, (c <= 1 + w1));
        if (c <= 1 + w1) chk32("wr_awaddr", awaddr, addr);
        chk1("wr_wvalid", wvalid, (c <= 1 + w2));
        if (c <= 1 + w2) chk32("wr_wdata", wdata, din);
        chk1("wr_bready", bready, (c >= 2 + m) && (c <= 2 + m + w3));
        chk1("wr_arvalid", arvalid, 1'b0);
        chk1("wr_rready", rready, 1'b0);
      end
      chk1("m_ready", m_ready, (c == d));
      chk32("m_dout", m_dout, model_dout);
      chk32("wstrb", {28'h0, wstrb}, 32'hF);
`ifdef BRIDGE_ERR_EN
      chk1("m_err", m_err, (c == d) && (resp != 2'b00));
`endif
      // Slave reacts to what the bridge is presenting this cycle.
      obs_ar = arvalid; obs_r = rready; obs_aw = awvalid; obs_w = wvalid; obs_b = bready;
      slave_quiet();
      if (!rw) begin
        arready = obs_ar && (n1 >= w1);
        if (obs_ar) n1++;
        rvalid = obs_r && (n2 >= w2);
        if (obs_r) n2++;
        if (rvalid) begin
          rdata = rd_val;
          rresp = resp;
          capt  = rd_val;
        end
      end else begin
        awready = obs_aw && (n1 >= w1);
        if (obs_aw) n1++;
        wready = obs_w && (n2 >= w2);
        if (obs_w) n2++;
        bvalid = obs_b && (n3 >= w3);
        if (obs_b) n3++;
        if (bvalid) bresp = resp;
      end
      if (c < d) begin
        // Inputs may wander once the request has been accepted.
        m_a   = $urandom;
        m_din = $urandom;
        m_rw  = 1'($urandom);
      end else begin
        m_strobe = keep;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit keep;
    logic [31:0] last_addr;
    clrn = 1'b0;
    m_a = '0; m_din = '0; m_strobe = 1'b0; m_rw = 1'b0;
    slave_quiet();
    model_dout = '0;
    #12;
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_m_ready", m_ready, 1'b0);
    chk32("rst_m_dout", m_dout, 32'h0);
    chk32("rst_araddr", araddr, 32'h0);
    chk32("rst_awaddr", awaddr, 32'h0);
    chk32("rst_wdata", wdata, 32'h0);
    chk32("rst_wstrb", {28'h0, wstrb}, 32'hF);
`ifdef BRIDGE_ERR_EN
    chk1("rst_m_err", m_err, 1'b0);
`endif
    @(negedge clk);
    clrn = 1'b1;
    idle_cycles(2);

    // Zero-wait read.
    run_txn(1'b0, 32'h1FC00000, 32'h0, 0, 0, 0, 32'h3C1DBFC0, 2'b00, 1'b0);
    idle_cycles(1);
    // Read with arready held off 4 cycles and rvalid delayed 2.
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4, 2, 0, 32'h1234_5678, 2'b00, 1'b0);
    idle_cycles(1);
    // Split write: address accepted first, data two cycles later.
    run_txn(1'b1, 32'h0000_0100, 32'hDEADBEEF, 0, 2, 0, 32'h0, 2'b00, 1'b0);
    idle_cycles(1);
    // Back-to-back reads with strobe held across m_ready.
    run_txn(1'b0, 32'h0000_0100, 32'h0, 0, 0, 0, 32'hCAFE_0100, 2'b00, 1'b1);
    run_txn(1'b0, 32'h0000_0104, 32'h0, 0, 0, 0, 32'hCAFE_0104, 2'b00, 1'b0);
    idle_cycles(1);
    // Error response on a write, then an OKAY read.
    run_txn(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 1, 0, 1, 32'h0, 2'b10, 1'b0);
    run_txn(1'b0, 32'h0000_0204, 32'h0, 0, 1, 0, 32'h600D_600D, 2'b00, 1'b0);
    idle_cycles(1);

    // Reset while waiting in RD_DATA.
    step();
    m_strobe = 1'b1; m_rw = 1'b0; m_a = 32'hA5A5_0000;
    step();
    chk1("rstmid_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk1("rstmid_rready_before", rready, 1'b1);
    #2 clrn = 1'b0;
    #1;
    chk1("rstmid_rready", rready, 1'b0);
    chk1("rstmid_m_ready", m_ready, 1'b0);
    chk1("rstmid_arvalid_clr", arvalid, 1'b0);
    chk32("rstmid_araddr", araddr, 32'h0);
    chk32("rstmid_m_dout", m_dout, 32'h0);
    model_dout = '0;
    m_strobe = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    idle_cycles(3);

    // Randomized traffic, occasionally reusing an address back-to-back.
    keep = 1'b0;
    last_addr = 32'h0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? last_addr : ($urandom & 32'hFFFF_FFFC);
      last_addr = a;
      keep = (i != 39) && ($urandom_range(0, 2) == 0);
      run_txn(1'($urandom), a, $urandom,
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom, 2'($urandom), keep);
      if (!keep) idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
